// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding, default widths and the NOP word for the fetch unit
package fetch_pkg;
  typedef enum logic [1:0] {BOOT, FETCH, HALTED, FAULT} fetch_state_e;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;
  localparam logic [DEF_DATA_W-1:0] NOP = 16'h0000;
endpackage

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: PC owner driving memread/address, one-entry IR handed to decode via valid/ready
// Ports: clk/rst_n; memread, address (=pc), readdata; redirect_valid/redirect_pc, halt;
//        ir_valid/ir_ready/ir_data/ir_pc toward decode; fault is a sticky out-of-range flag.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int MEM_DEPTH = 256,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              memread,
  output logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] readdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [DATA_W-1:0] ir_data,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              fault
);
  fetch_state_e state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, ir_pc_q, ir_pc_d;
  logic [DATA_W-1:0] ir_data_q, ir_data_d;
  logic ir_valid_q, ir_valid_d, fault_q, fault_d;
  logic in_range, xfer;
  // extra bit so MEM_DEPTH == 2^ADDR_W still compares correctly
  assign in_range = {1'b0, pc_q} < (ADDR_W+1)'(MEM_DEPTH);
  assign xfer = ir_valid_q & ir_ready;
  assign memread = (state_q == FETCH) & in_range;
  assign address = pc_q;
  assign ir_valid = ir_valid_q;
  assign ir_data = ir_data_q;
  assign ir_pc = ir_pc_q;
  assign fault = fault_q;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_valid_d = ir_valid_q & ~xfer;
    ir_data_d = ir_data_q;
    ir_pc_d = ir_pc_q;
    fault_d = fault_q;
    if (state_q == FAULT) begin
      state_d = FAULT;
    end else if (redirect_valid) begin
      pc_d = redirect_pc;
      ir_valid_d = 1'b0;
      state_d = halt ? HALTED : FETCH;
    end else if (halt) begin
      state_d = HALTED;
    end else if (state_q == FETCH) begin
      if (!in_range) begin
        state_d = FAULT;
        fault_d = 1'b1;
      end else if (!ir_valid_q || xfer) begin
        ir_data_d = readdata;
        ir_pc_d = pc_q;
        ir_valid_d = 1'b1;
        pc_d = pc_q + ADDR_W'(1);
      end
    end else begin
      state_d = FETCH;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q <= RESET_PC;
      ir_valid_q <= 1'b0;
      ir_data_q <= '0;
      ir_pc_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_valid_q <= ir_valid_d;
      ir_data_q <= ir_data_d;
      ir_pc_q <= ir_pc_d;
      fault_q <= fault_d;
    end
  end
endmodule
